instruction_encoder: RTL and testbench

- Inverse of the decode-side immediate path: packs an instruction selector, register indices and a full 32-bit immediate into a 32-bit instruction word for the supported subset: ADD, XOR, SLT, AUIPC, LUI, ADDI, LW, ANDI, SRAI, BEQ, JAL, SW, ABSV.
- Streams encoded words, with a write address, toward instruction memory. Used by the program loader and by benches that generate decoder stimulus.
- Single-register pipeline with valid/ready on both sides, immediate range checking, and word/error counters.

---
 rtl/rv_enc_pkg.sv | 64 ++++++
 rtl/imm_scatter.sv | 54 +++++
 rtl/instruction_encoder.sv | 194 +++++++++++++++++++
 tb/tb_instruction_encoder.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_enc_pkg.sv
// Shared constants for the RV32 subset instruction encoder.
// Op selectors, opcode/funct fields, formats and error codes.
package rv_enc_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_XOR   = 4'd1;
  localparam logic [3:0] OP_SLT   = 4'd2;
  localparam logic [3:0] OP_AUIPC = 4'd3;
  localparam logic [3:0] OP_LUI   = 4'd4;
  localparam logic [3:0] OP_ADDI  = 4'd5;
  localparam logic [3:0] OP_LW    = 4'd6;
  localparam logic [3:0] OP_ANDI  = 4'd7;
  localparam logic [3:0] OP_SRAI  = 4'd8;
  localparam logic [3:0] OP_BEQ   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_SW    = 4'd11;
  localparam logic [3:0] OP_ABSV  = 4'd12;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_CUST0  = 7'b0001011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_SRA  = 3'b101;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SRA  = 7'b0100000;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_RANGE   = 2'd2;
  localparam logic [1:0] ERR_ALIGN   = 2'd3;

  // True when v is representable as an n-bit signed value.
  function automatic logic fits(
    input logic [31:0] v,
    input int unsigned n
  );
    logic [31:0] hi;
    hi = $signed(v) >>> (n - 1);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/imm_scatter.sv
// Places a 32-bit immediate into its instruction bit positions
// for the given format and flags range / alignment problems.
module imm_scatter
  import rv_enc_pkg::*;
(
  input  fmt_t        fmt,
  input  logic        shamt,
  input  logic [31:0] imm,
  output logic [31:0] bits,
  output logic        range_ok,
  output logic        align_ok
);

  // Per-format scatter and legality of the immediate.
  always_comb begin
    bits     = '0;
    range_ok = 1'b1;
    align_ok = 1'b1;
    case (fmt)
      FMT_I: begin
        if (shamt) begin
          bits     = {F7_SRA, imm[4:0], 20'b0};
          range_ok = (imm[31:5] == '0);
        end else begin
          bits     = {imm[11:0], 20'b0};
          range_ok = fits(imm, 12);
        end
      end
      FMT_S: begin
        bits = {imm[11:5], 13'b0,
                imm[4:0], 7'b0};
        range_ok = fits(imm, 12);
      end
      FMT_B: begin
        bits = {imm[12], imm[10:5], 13'b0,
                imm[4:1], imm[11], 7'b0};
        range_ok = fits(imm, 13);
        align_ok = !imm[0];
      end
      FMT_U: begin
        bits     = {imm[31:12], 12'b0};
        range_ok = (imm[11:0] == '0);
      end
      FMT_J: begin
        bits = {imm[20], imm[10:1], imm[11],
                imm[19:12], 12'b0};
        range_ok = fits(imm, 21);
        align_ok = !imm[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// Packs op/register/immediate requests into RV32 words and
// streams them with a wrapping write address toward memory.
module instruction_encoder
  import rv_enc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        done,
  output logic        err_valid,
  output logic [1:0]  err_code,
  output logic [15:0] word_count
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [AW-1:0] IDX_ONE = {{(AW-1){1'b0}}, 1'b1};

  fmt_t        fmt;
  logic        legal;
  logic        shamt;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd_f;
  logic [4:0]  rs1_f;
  logic [4:0]  rs2_f;
  logic [31:0] imm_bits;
  logic        range_ok;
  logic        align_ok;
  logic [31:0] word;
  logic [1:0]  code;
  logic        ok;
  logic        in_fire;
  logic        out_fire;
  logic        out_last;
  logic        rej_last;
  logic [AW-1:0] idx;

  // Select format, fixed fields and used register slots per op.
  always_comb begin
    fmt   = FMT_R;
    legal = 1'b1;
    shamt = 1'b0;
    opc   = '0;
    f3    = '0;
    f7    = '0;
    rd_f  = '0;
    rs1_f = '0;
    rs2_f = '0;
    case (in_op)
      OP_ADD, OP_XOR, OP_SLT: begin
        opc   = OPC_OP;
        f7    = F7_BASE;
        rd_f  = in_rd;
        rs1_f = in_rs1;
        rs2_f = in_rs2;
        f3    = (in_op == OP_XOR) ? F3_XOR :
                (in_op == OP_SLT) ? F3_SLT : F3_ADD;
      end
      OP_ABSV: begin
        opc   = OPC_CUST0;
        f3    = F3_ADD;
        rd_f  = in_rd;
        rs1_f = in_rs1;
      end
      OP_ADDI, OP_ANDI, OP_SRAI, OP_LW: begin
        fmt   = FMT_I;
        rd_f  = in_rd;
        rs1_f = in_rs1;
        opc   = (in_op == OP_LW) ? OPC_LOAD : OPC_OPIMM;
        shamt = (in_op == OP_SRAI);
        f3    = (in_op == OP_ANDI) ? F3_AND :
                (in_op == OP_SRAI) ? F3_SRA :
                (in_op == OP_LW)   ? F3_WORD : F3_ADD;
      end
      OP_SW: begin
        fmt   = FMT_S;
        opc   = OPC_STORE;
        f3    = F3_WORD;
        rs1_f = in_rs1;
        rs2_f = in_rs2;
      end
      OP_BEQ: begin
        fmt   = FMT_B;
        opc   = OPC_BRANCH;
        f3    = F3_BEQ;
        rs1_f = in_rs1;
        rs2_f = in_rs2;
      end
      OP_JAL: begin
        fmt  = FMT_J;
        opc  = OPC_JAL;
        rd_f = in_rd;
      end
      OP_LUI, OP_AUIPC: begin
        fmt  = FMT_U;
        rd_f = in_rd;
        opc  = (in_op == OP_LUI) ? OPC_LUI : OPC_AUIPC;
      end
      default: legal = 1'b0;
    endcase
  end

  imm_scatter u_scatter (
    .fmt      (fmt),
    .shamt    (shamt),
    .imm      (in_imm),
    .bits     (imm_bits),
    .range_ok (range_ok),
    .align_ok (align_ok)
  );

  assign word = imm_bits |
                {f7, rs2_f, rs1_f, f3, rd_f, opc};

  // Illegal op first, then misalignment, then range.
  always_comb begin
    code = ERR_NONE;
    if (!legal)         code = ERR_ILLEGAL;
    else if (!align_ok) code = ERR_ALIGN;
    else if (!range_ok) code = ERR_RANGE;
  end

  assign ok       = (code == ERR_NONE);
  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign done     = (out_fire && out_last) || rej_last;
  assign out_addr = BASE_ADDR + (32'(idx) << 2);

  // Output holding register: load on a legal accept, drain on ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_last  <= 1'b0;
    end else if (in_fire && ok) begin
      out_valid <= 1'b1;
      out_instr <= word;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Error pulse and the done pulse owed to a rejected last request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
      rej_last  <= 1'b0;
    end else begin
      err_valid <= in_fire && !ok;
      rej_last  <= in_fire && !ok && in_last;
      if (in_fire && !ok) err_code <= code;
    end
  end

  // Word index behind out_addr; wraps naturally at MEM_WORDS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if ((in_fire && !ok && in_last) ||
                 (out_fire && out_last)) begin
      idx <= '0;
    end else if (out_fire) begin
      idx <= idx + IDX_ONE;
    end
  end

  // Saturating count of words taken by memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_count <= '0;
    end else if (out_fire && word_count != 16'hFFFF) begin
      word_count <= word_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: directed cases from
// the test plan followed by randomized requests and back-pressure.
module tb_instruction_encoder;

  localparam int          MW   = 4;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        done;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [15:0] word_count;

  always #5 clk = ~clk;

  instruction_encoder #(
    .BASE_ADDR (BASE),
    .MEM_WORDS (MW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_addr   (out_addr),
    .done       (done),
    .err_valid  (err_valid),
    .err_code   (err_code),
    .word_count (word_count)
  );

  typedef struct {
    logic [31:0] w;
    logic [31:0] a;
    logic        last;
  } wexp_t;

  typedef struct {
    logic [1:0] c;
    logic       last;
  } eexp_t;

  wexp_t wq[$];
  eexp_t eq[$];
  int n_cmp   = 0;
  int n_bad   = 0;
  int seq_n   = 0;
  int exp_cnt = 0;
  int mode    = 2;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference encoder written from the ISA field tables.
  function automatic void model(
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] w,
    output logic [1:0]  e
  );
    int s;
    s = $signed(imm);
    w = '0;
    e = 2'd0;
    case (op)
      4'd0: w = {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
      4'd1: w = {7'b0, rs2, rs1, 3'b100, rd, 7'b0110011};
      4'd2: w = {7'b0, rs2, rs1, 3'b010, rd, 7'b0110011};
      4'd12: w = {12'b0, rs1, 3'b000, rd, 7'b0001011};
      4'd3, 4'd4: begin
        if (imm[11:0] != 0) e = 2'd2;
        else w = {imm[31:12], rd,
                  (op == 4'd4) ? 7'b0110111 : 7'b0010111};
      end
      4'd5, 4'd6, 4'd7: begin
        if (s < -2048 || s > 2047) e = 2'd2;
        else if (op == 4'd5)
          w = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
        else if (op == 4'd6)
          w = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
        else
          w = {imm[11:0], rs1, 3'b111, rd, 7'b0010011};
      end
      4'd8: begin
        if (s < 0 || s > 31) e = 2'd2;
        else w = {7'b0100000, imm[4:0], rs1, 3'b101,
                  rd, 7'b0010011};
      end
      4'd9: begin
        if (imm[0]) e = 2'd3;
        else if (s < -4096 || s > 4094) e = 2'd2;
        else w = {imm[12], imm[10:5], rs2, rs1, 3'b000,
                  imm[4:1], imm[11], 7'b1100011};
      end
      4'd10: begin
        if (imm[0]) e = 2'd3;
        else if (s < -1048576 || s > 1048574) e = 2'd2;
        else w = {imm[20], imm[10:1], imm[11],
                  imm[19:12], rd, 7'b1101111};
      end
      4'd11: begin
        if (s < -2048 || s > 2047) e = 2'd2;
        else w = {imm[11:5], rs2, rs1, 3'b010,
                  imm[4:0], 7'b0100011};
      end
      default: e = 2'd1;
    endcase
  endfunction

  task automatic set_mode(input int m);
    mode = m;
    if (m != 0) out_ready = (m == 2);
  endtask

  task automatic send(input logic [3:0]  op,
                      input logic [4:0]  rd,
                      input logic [4:0]  rs1,
                      input logic [4:0]  rs2,
                      input logic [31:0] imm,
                      input logic        last);
    logic [31:0] w;
    logic [1:0]  e;
    bit          acc;
    acc      = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
    in_last  = last;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        model(op, rd, rs1, rs2, imm, w, e);
        if (e == 2'd0) begin
          wq.push_back('{w: w,
                         a: BASE + 32'((seq_n % MW) * 4),
                         last: last});
          exp_cnt++;
          seq_n = last ? 0 : seq_n + 1;
        end else begin
          eq.push_back('{c: e, last: last});
          if (last) seq_n = 0;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got no accept expected accept");
    end
  endtask

  task automatic drain();
    set_mode(2);
    for (int i = 0; i < 100 && (wq.size() + eq.size()) > 0; i++)
      @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("drain_words", wq.size(), 0);
    check("drain_errs", eq.size(), 0);
    check("word_count", word_count, exp_cnt);
  endtask

  function automatic logic [31:0] rand_imm();
    int v;
    logic [31:0] r;
    int bnd[16] = '{2047, 2048, -2048, -2049, 4094, 4095,
                    -4096, -4098, 1048574, -1048576, 1048576,
                    31, 32, 0, -1, 4096};
    case ($urandom % 6)
      0: v = int'($urandom_range(80)) - 40;
      1: v = bnd[$urandom % 16];
      2: v = int'($urandom);
      3: v = int'($urandom_range(8200)) - 4100;
      4: v = int'($urandom_range(2200000)) - 1100000;
      default: begin
        r = $urandom;
        r[11:0] = '0;
        v = int'(r);
      end
    endcase
    return 32'(v);
  endfunction

  // out_ready driver: random in mode 0, forced otherwise.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mode == 0) out_ready = ($urandom % 4) != 0;
      else           out_ready = (mode == 2);
    end
  end

  // Monitor: pops expectations whenever the DUT presents a result.
  initial begin
    bit          held;
    logic [31:0] h_i;
    logic [31:0] h_a;
    logic        exp_done;
    bit          any;
    wexp_t       x;
    eexp_t       y;
    held = 0;
    h_i  = '0;
    h_a  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 0;
      end else begin
        if (held) begin
          check("hold_valid", out_valid, 1);
          check("hold_instr", out_instr, h_i);
          check("hold_addr", out_addr, h_a);
        end
        held     = out_valid && !out_ready;
        h_i      = out_instr;
        h_a      = out_addr;
        exp_done = 1'b0;
        any      = 0;
        if (out_valid && out_ready) begin
          any = 1;
          if (wq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_word: got %h expected none",
                     out_instr);
          end else begin
            x = wq.pop_front();
            check("out_instr", out_instr, x.w);
            check("out_addr", out_addr, x.a);
            exp_done |= x.last;
          end
        end
        if (err_valid) begin
          any = 1;
          if (eq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_err: got %0d expected none",
                     err_code);
          end else begin
            y = eq.pop_front();
            check("err_code", err_code, y.c);
            exp_done |= y.last;
          end
        end
        if (any || done) check("done", done, exp_done);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_addr", out_addr, BASE);
    check("rst_done", done, 0);
    check("rst_err_valid", err_valid, 0);
    check("rst_err_code", err_code, 0);
    check("rst_word_count", word_count, 0);
    rst = 1'b0;

    send(4'd5, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 0);
    check("latency_valid", out_valid, 1);
    check("addi_word", out_instr, 32'hFFF0_0093);
    send(4'd9, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 0);
    send(4'd9, 5'd0, 5'd1, 5'd2, 32'd3, 0);
    send(4'd10, 5'd1, 5'd0, 5'd0, 32'd2048, 0);
    send(4'd4, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 0);
    send(4'd4, 5'd5, 5'd0, 5'd0, 32'h1234_5001, 0);
    drain();

    set_mode(1);
    fork
      begin
        send(4'd11, 5'd0, 5'd3, 5'd4, 32'd16, 0);
        send(4'd11, 5'd0, 5'd3, 5'd5, 32'hFFFF_F800, 0);
        send(4'd11, 5'd0, 5'd3, 5'd6, 32'd2047, 1);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        set_mode(2);
      end
    join
    for (int i = 0; i < 5; i++)
      send(4'd0, 5'(i), 5'd2, 5'd3, 32'd0, 0);
    send(4'd14, 5'd1, 5'd1, 5'd1, 32'd0, 1);
    send(4'd12, 5'd7, 5'd8, 5'd9, 32'd0, 0);
    drain();

    set_mode(1);
    send(4'd5, 5'd2, 5'd2, 5'd0, 32'd7, 0);
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("rst_drop_valid", out_valid, 0);
    check("rst_addr", out_addr, BASE);
    wq.delete();
    eq.delete();
    seq_n   = 0;
    exp_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    set_mode(2);
    send(4'd14, 5'd1, 5'd1, 5'd1, 32'd0, 0);
    send(4'd8, 5'd3, 5'd4, 5'd0, 32'd31, 0);
    send(4'd8, 5'd3, 5'd4, 5'd0, 32'd32, 0);
    drain();

    set_mode(0);
    for (int i = 0; i < 400; i++) begin
      send(4'($urandom_range(15)), 5'($urandom),
           5'($urandom), 5'($urandom), rand_imm(),
           ($urandom % 8) == 0);
      if (($urandom % 4) == 0) begin
        repeat ($urandom_range(3)) @(posedge clk);
        #1;
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
